// File: rtl/dff_edge_debounce.sv
// Synchronises an asynchronous level, debounces it over STABLE_CYCLES enabled samples, and emits rise/fall pulses.
// Optional commit counter output evt_cnt is enabled by defining DEBOUNCE_EVT_CNT_EN.
module dff_edge_debounce #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8,
    parameter bit INIT_LEVEL    = 1'b0
) (
    input  logic        clk,
    input  logic        Rd,
    input  logic        en,
    input  logic        d_in,
    output logic        level,
    output logic        rise,
    output logic        fall,
    output logic        busy
`ifdef DEBOUNCE_EVT_CNT_EN
    ,
    output logic [15:0] evt_cnt
`endif
);

    typedef enum logic {
        STABLE = 1'b0,
        VERIFY = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_p;
    logic                   s;
    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic                   commit;

    assign s = sync_p[SYNC_STAGES-1];

    // Synchroniser stage: shifts every clock, independent of en
    always_ff @(posedge clk or negedge Rd) begin
        if (!Rd) begin
            sync_p <= {SYNC_STAGES{INIT_LEVEL}};
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], d_in};
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        unique case (state)
            STABLE: begin
                if (en && (s != level)) begin
                    if (STABLE_CYCLES == 1) begin
                        commit = 1'b1;
                    end else begin
                        state_nxt = VERIFY;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            VERIFY: begin
                if (en) begin
                    if (s == level) begin
                        state_nxt = STABLE;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                        commit    = 1'b1;
                        state_nxt = STABLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = STABLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Debounce stage: state, counter and registered outputs
    always_ff @(posedge clk or negedge Rd) begin
        if (!Rd) begin
            state <= STABLE;
            cnt   <= '0;
            level <= INIT_LEVEL;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            level <= level ^ commit;
            rise  <= commit & ~level;
            fall  <= commit & level;
            busy  <= (state_nxt == VERIFY);
        end
    end

`ifdef DEBOUNCE_EVT_CNT_EN
    // Commit counter wraps naturally at 16 bits
    always_ff @(posedge clk or negedge Rd) begin
        if (!Rd) begin
            evt_cnt <= '0;
        end else if (commit) begin
            evt_cnt <= evt_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dff_edge_debounce.sv
// Directed bench for dff_edge_debounce at default parameters (SYNC_STAGES=2, STABLE_CYCLES=4).
module tb_dff_edge_debounce;

    logic clk = 1'b0;
    logic Rd;
    logic en;
    logic d_in;
    logic level;
    logic rise;
    logic fall;
    logic busy;
`ifdef DEBOUNCE_EVT_CNT_EN
    logic [15:0] evt_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int pulse_cnt = 0;
    int both_bad  = 0;
    int en_bad    = 0;
    logic en_last = 1'b1;

    dff_edge_debounce dut (
        .clk    (clk),
        .Rd     (Rd),
        .en     (en),
        .d_in   (d_in),
        .level  (level),
        .rise   (rise),
        .fall   (fall),
        .busy   (busy)
`ifdef DEBOUNCE_EVT_CNT_EN
        ,
        .evt_cnt(evt_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) en_last <= en;

    always @(negedge clk) begin
        pulse_cnt <= pulse_cnt + (rise ? 1 : 0) + (fall ? 1 : 0);
        if (rise && fall) both_bad <= both_bad + 1;
        if ((rise || fall) && !en_last) en_bad <= en_bad + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        Rd = 1'b0;
        #2;
        Rd = 1'b1;
    endtask

    int p0;

    initial begin
        Rd   = 1'b1;
        en   = 1'b1;
        d_in = 1'b1;

        // 1: asynchronous reset, then release with d_in=1
        #1 Rd = 1'b0;
        #1;
        check("rst_level", 32'(level), 32'd0);
        check("rst_rise",  32'(rise),  32'd0);
        check("rst_fall",  32'(fall),  32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        Rd = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            tick();
            if (i == 4) check("rst_rel_level_e4", 32'(level), 32'd0);
            if (i == 5) begin
                check("rst_rel_level_e5", 32'(level), 32'd1);
                check("rst_rel_rise_e5",  32'(rise),  32'd1);
            end
        end

        // 2: clean rise from level 0
        d_in = 1'b0;
        pulse_reset();
        check("clean_pre_level", 32'(level), 32'd0);
        d_in = 1'b1;
        for (int i = 0; i <= 6; i++) begin
            tick();
            if (i == 1) check("clean_busy_e1", 32'(busy), 32'd0);
            if (i == 2) check("clean_busy_e2", 32'(busy), 32'd1);
            if (i == 4) check("clean_level_e4", 32'(level), 32'd0);
            if (i == 5) begin
                check("clean_level_e5", 32'(level), 32'd1);
                check("clean_rise_e5",  32'(rise),  32'd1);
                check("clean_fall_e5",  32'(fall),  32'd0);
            end
            if (i == 6) begin
                check("clean_rise_e6", 32'(rise), 32'd0);
                check("clean_busy_e6", 32'(busy), 32'd0);
            end
        end

        // 3: two-cycle glitch is rejected
        d_in = 1'b0;
        pulse_reset();
        tick(); tick(); tick();
        p0 = pulse_cnt;
        d_in = 1'b1;
        for (int i = 0; i <= 9; i++) begin
            if (i == 2) d_in = 1'b0;
            tick();
            if (i == 2) check("glitch_busy_e2", 32'(busy), 32'd1);
            if (i == 4) check("glitch_busy_e4", 32'(busy), 32'd0);
        end
        check("glitch_level",  32'(level), 32'd0);
        check("glitch_pulses", 32'(pulse_cnt - p0), 32'd0);

        // 4: enable gating on a falling change
        d_in = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        check("gate_pre_level", 32'(level), 32'd1);
        d_in = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            en = ((i % 4) == 3);
            tick();
            if (i == 3)  check("gate_busy_e3",   32'(busy),  32'd1);
            if (i == 14) check("gate_level_e14", 32'(level), 32'd1);
            if (i == 15) begin
                check("gate_level_e15", 32'(level), 32'd0);
                check("gate_fall_e15",  32'(fall),  32'd1);
            end
            if (i == 16) check("gate_fall_e16", 32'(fall), 32'd0);
        end
        en = 1'b1;

        // 5: reset while a change is being verified
        d_in = 1'b1;
        for (int i = 0; i <= 3; i++) tick();
        check("midv_busy", 32'(busy), 32'd1);
        Rd = 1'b0;
        #1;
        check("midv_rst_busy",  32'(busy),  32'd0);
        check("midv_rst_level", 32'(level), 32'd0);
        d_in = 1'b0;
        #1 Rd = 1'b1;
        p0 = pulse_cnt;
        for (int i = 0; i < 8; i++) tick();
        check("midv_pulses", 32'(pulse_cnt - p0), 32'd0);
        check("midv_level",  32'(level), 32'd0);
        check("midv_busy_after", 32'(busy), 32'd0);

        // 6: three full 0->1->0 cycles
        p0 = pulse_cnt;
        for (int c = 0; c < 3; c++) begin
            d_in = 1'b1;
            for (int i = 0; i < 8; i++) tick();
            d_in = 1'b0;
            for (int i = 0; i < 8; i++) tick();
        end
        check("cyc_pulses", 32'(pulse_cnt - p0), 32'd6);
        check("cyc_level",  32'(level), 32'd0);
`ifdef DEBOUNCE_EVT_CNT_EN
        check("evt_cnt",        32'(evt_cnt), 32'd6);
        check("evt_cnt_pulses", 32'(evt_cnt), 32'(pulse_cnt - p0));
`endif

        check("both_pulses", 32'(both_bad), 32'd0);
        check("pulse_no_en", 32'(en_bad),   32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
